// File: rtl/rx78_io_port_pkg.sv
// Shared definitions for the RX-78 I/O-space responder: port addresses,
// decoded port selector and the address decode helper.
package rx78_io_port_pkg;

   localparam logic [7:0] PORT_RBANK  = 8'hF1;
   localparam logic [7:0] PORT_WBANK  = 8'hF2;
   localparam logic [7:0] PORT_KBD    = 8'hF4;
   localparam logic [7:0] PORT_PAL0   = 8'hF5;
   localparam logic [7:0] PORT_INTC   = 8'hFD;
   localparam logic [7:0] PORT_BGMASK = 8'hFE;

   // Bits of the interrupt-control register as seen on reads and writes
   localparam int INTC_EN_BIT    = 0;
   localparam int INTC_CLEAR_BIT = 1;

   typedef enum logic [2:0] {
      SEL_NONE,
      SEL_RBANK,
      SEL_WBANK,
      SEL_KBD,
      SEL_PAL,
      SEL_INTC,
      SEL_BGMASK
   } port_sel_e;

   // Fixed ports take precedence; the palette window covers PORT_PAL0 upwards.
   function automatic port_sel_e decode_port(input logic [7:0] addr, input int pal_regs);
      port_sel_e sel;
      case (addr)
         PORT_RBANK:  sel = SEL_RBANK;
         PORT_WBANK:  sel = SEL_WBANK;
         PORT_KBD:    sel = SEL_KBD;
         PORT_INTC:   sel = SEL_INTC;
         PORT_BGMASK: sel = SEL_BGMASK;
         default:     sel = SEL_NONE;
      endcase
      if (sel == SEL_NONE && int'(addr) >= int'(PORT_PAL0) &&
          int'(addr) < int'(PORT_PAL0) + pal_regs)
         sel = SEL_PAL;
      return sel;
   endfunction

endpackage

// File: rtl/rx78_sync_edge.sv
// Two-flop synchroniser with a rising-edge pulse on the synchronised output.
// The edge flop is left unconnected (and trimmed) where only the level is needed.
module rx78_sync_edge #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] rise
);

   logic [WIDTH-1:0] meta;
   logic [WIDTH-1:0] sync;
   logic [WIDTH-1:0] prev;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta <= '0;
         sync <= '0;
         prev <= '0;
      end else begin
         meta <= d;
         sync <= meta;
         prev <= sync;
      end
   end

   assign q    = sync;
   assign rise = sync & ~prev;

endmodule

// File: rtl/rx78_io_port.sv
// Z80 I/O-space responder for the RX-78: bank, keyboard, palette, background and
// interrupt-control registers, vblank interrupt and interrupt-acknowledge vector.
module rx78_io_port
   import rx78_io_port_pkg::*;
#(
   parameter logic [7:0] INT_VECTOR = 8'hFF,
   parameter int         PAL_REGS   = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  iorq_n,
   input  logic                  m1_n,
   input  logic                  rd_n,
   input  logic                  wr_n,
   input  logic [7:0]            addr,
   input  logic [7:0]            din,
   output logic [7:0]            dout,
   input  logic                  vb,
   output logic                  int_n,
   output logic [7:0]            vram_rbank,
   output logic [7:0]            vram_wbank,
   output logic [3:0]            kbd_strobe,
   input  logic [7:0]            kbd_cols,
   output logic [8*PAL_REGS-1:0] pal,
   output logic [7:0]            bg_mask
);

   logic      io_wr;
   logic      io_rd;
   logic      io_ack;
   logic      wr_seen;
   logic      ack_seen;
   logic      wr_start;
   logic      ack_start;
   port_sel_e sel;

   logic [7:0] pal_q [PAL_REGS];
   logic       int_en;
   logic       int_pend;

   logic [7:0] kbd_sync;
   logic [7:0] kbd_rise_unused;
   logic       vb_level_unused;
   logic       vb_rise;

   assign io_wr  = ~iorq_n & ~wr_n & m1_n;
   assign io_rd  = ~iorq_n & ~rd_n & m1_n;
   assign io_ack = ~iorq_n & ~m1_n;

   assign wr_start  = io_wr  & ~wr_seen;
   assign ack_start = io_ack & ~ack_seen;

   assign sel = decode_port(addr, PAL_REGS);

   rx78_sync_edge #(.WIDTH(1)) u_vb_sync (
      .clk   (clk),
      .reset (reset),
      .d     (vb),
      .q     (vb_level_unused),
      .rise  (vb_rise)
   );

   rx78_sync_edge #(.WIDTH(8)) u_kbd_sync (
      .clk   (clk),
      .reset (reset),
      .d     (kbd_cols),
      .q     (kbd_sync),
      .rise  (kbd_rise_unused)
   );

   // NOTE: the strobe trackers come out of reset as "already seen" so a write or ack
   // still held across reset release is not treated as a fresh cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_seen  <= 1'b1;
         ack_seen <= 1'b1;
      end else begin
         wr_seen  <= io_wr;
         ack_seen <= io_ack;
      end
   end

   // NOTE: the palette is a handful of flops, not a RAM, so it is reset like any register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vram_rbank <= '0;
         vram_wbank <= '0;
         kbd_strobe <= '0;
         bg_mask    <= '0;
         int_en     <= 1'b0;
         for (int k = 0; k < PAL_REGS; k++)
            pal_q[k] <= '0;
      end else if (wr_start) begin
         case (sel)
            SEL_RBANK:  vram_rbank <= din;
            SEL_WBANK:  vram_wbank <= din;
            SEL_KBD:    kbd_strobe <= din[3:0];
            SEL_BGMASK: bg_mask    <= din;
            SEL_INTC:   int_en     <= din[INTC_EN_BIT];
            SEL_PAL: begin
               for (int k = 0; k < PAL_REGS; k++)
                  if (int'(addr) == int'(PORT_PAL0) + k)
                     pal_q[k] <= din;
            end
            default: ;
         endcase
      end
   end

   // A new vblank request outranks any clear arriving in the same clk.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         int_pend <= 1'b0;
         int_n    <= 1'b1;
      end else begin
         if (vb_rise)
            int_pend <= 1'b1;
         else if (ack_start)
            int_pend <= 1'b0;
         else if (wr_start && sel == SEL_INTC && din[INTC_CLEAR_BIT])
            int_pend <= 1'b0;
         int_n <= ~(int_pend & int_en);
      end
   end

   for (genvar g = 0; g < PAL_REGS; g++) begin : g_pal
      assign pal[8*g +: 8] = pal_q[g];
   end

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      dout = '0;
      if (io_ack) begin
         dout = INT_VECTOR;
      end else if (io_rd) begin
         case (sel)
            SEL_RBANK:  dout = vram_rbank;
            SEL_WBANK:  dout = vram_wbank;
            SEL_KBD:    dout = kbd_sync;
            SEL_BGMASK: dout = bg_mask;
            SEL_INTC:   dout = {6'b0, int_pend, int_en};
            SEL_PAL: begin
               for (int k = 0; k < PAL_REGS; k++)
                  if (int'(addr) == int'(PORT_PAL0) + k)
                     dout = pal_q[k];
            end
            default:    dout = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_rx78_io_port.sv
// Self-checking bench for rx78_io_port: read data is checked against a queue of
// expected values pushed when each IN cycle is issued.
module tb_rx78_io_port;

   localparam int PAL_REGS = 6;

   logic                  clk;
   logic                  reset;
   logic                  iorq_n;
   logic                  m1_n;
   logic                  rd_n;
   logic                  wr_n;
   logic [7:0]            addr;
   logic [7:0]            din;
   logic [7:0]            dout;
   logic                  vb;
   logic                  int_n;
   logic [7:0]            vram_rbank;
   logic [7:0]            vram_wbank;
   logic [3:0]            kbd_strobe;
   logic [7:0]            kbd_cols;
   logic [8*PAL_REGS-1:0] pal;
   logic [7:0]            bg_mask;

   int         errors = 0;
   int         checks = 0;
   logic [7:0] exp_q[$];
   logic [7:0] got;
   logic [7:0] exp;

   rx78_io_port #(.INT_VECTOR(8'hFF), .PAL_REGS(PAL_REGS)) dut (
      .clk        (clk),
      .reset      (reset),
      .iorq_n     (iorq_n),
      .m1_n       (m1_n),
      .rd_n       (rd_n),
      .wr_n       (wr_n),
      .addr       (addr),
      .din        (din),
      .dout       (dout),
      .vb         (vb),
      .int_n      (int_n),
      .vram_rbank (vram_rbank),
      .vram_wbank (vram_wbank),
      .kbd_strobe (kbd_strobe),
      .kbd_cols   (kbd_cols),
      .pal        (pal),
      .bg_mask    (bg_mask)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic io_write(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      addr = a; din = d; m1_n = 1'b1; iorq_n = 1'b0; wr_n = 1'b0;
      repeat (2) @(negedge clk);
      iorq_n = 1'b1; wr_n = 1'b1;
   endtask

   task automatic io_read(input logic [7:0] a, output logic [7:0] data);
      @(negedge clk);
      addr = a; m1_n = 1'b1; iorq_n = 1'b0; rd_n = 1'b0;
      #1 data = dout;
      @(negedge clk);
      iorq_n = 1'b1; rd_n = 1'b1;
   endtask

   task automatic wait_int_low(input int budget, input string name);
      int n = 0;
      while (int_n !== 1'b0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (int_n !== 1'b0) begin
         errors++;
         $display("FAIL %s: int_n=%b after %0d clk, required 0 within %0d", name, int_n, n, budget);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (dout !== 8'h00 || int_n !== 1'b1 || vram_rbank !== 8'h00 || vram_wbank !== 8'h00 ||
          kbd_strobe !== 4'h0 || pal !== '0 || bg_mask !== 8'h00) begin
         errors++;
         $display("FAIL reset_state: dout=%h int_n=%b rbank=%h wbank=%h strobe=%h pal=%h bg=%h, required all 0 and int_n=1",
                  dout, int_n, vram_rbank, vram_wbank, kbd_strobe, pal, bg_mask);
      end
      reset = 1'b0;
      // Reset pulse in the middle of a held write to F2
      @(negedge clk);
      addr = 8'hF2; din = 8'h55; m1_n = 1'b1; iorq_n = 1'b0; wr_n = 1'b0;
      #2 reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      iorq_n = 1'b1; wr_n = 1'b1;
      @(negedge clk);
      checks++;
      if (vram_wbank !== 8'h00) begin
         errors++;
         $display("FAIL reset_midwrite_wbank: got %h required 00", vram_wbank);
      end
      checks++;
      if (int_n !== 1'b1) begin
         errors++;
         $display("FAIL reset_midwrite_int_n: got %b required 1", int_n);
      end
   endtask

   task automatic test_bank_regs();
      io_write(8'hF1, 8'h03);
      io_write(8'hF2, 8'h07);
      checks++;
      if (vram_rbank !== 8'h03 || vram_wbank !== 8'h07) begin
         errors++;
         $display("FAIL bank_outputs: rbank=%h wbank=%h required 03 07", vram_rbank, vram_wbank);
      end
      exp_q.push_back(8'h03);
      io_read(8'hF1, got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL read_F1: got %h required %h", got, exp); end
      exp_q.push_back(8'h07);
      io_read(8'hF2, got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL read_F2: got %h required %h", got, exp); end
      // Held strobe with data changing mid-hold: only the first value may land
      @(negedge clk);
      addr = 8'hF1; din = 8'h10; m1_n = 1'b1; iorq_n = 1'b0; wr_n = 1'b0;
      @(negedge clk);
      din = 8'h20;
      repeat (4) @(negedge clk);
      iorq_n = 1'b1; wr_n = 1'b1;
      @(negedge clk);
      checks++;
      if (vram_rbank !== 8'h10) begin
         errors++;
         $display("FAIL held_write_once: rbank=%h required 10", vram_rbank);
      end
      // Unmapped write leaves the mapped registers alone
      io_write(8'hF3, 8'hEE);
      checks++;
      if (vram_rbank !== 8'h10 || vram_wbank !== 8'h07 || bg_mask !== 8'h00) begin
         errors++;
         $display("FAIL unmapped_write: rbank=%h wbank=%h bg=%h required 10 07 00", vram_rbank, vram_wbank, bg_mask);
      end
   endtask

   task automatic test_keyboard();
      io_write(8'hF4, 8'hFA);
      checks++;
      if (kbd_strobe !== 4'hA) begin
         errors++;
         $display("FAIL kbd_strobe: got %h required a", kbd_strobe);
      end
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h81);
      @(negedge clk);
      kbd_cols = 8'h81;
      addr = 8'hF4; m1_n = 1'b1; iorq_n = 1'b0; rd_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge clk);
         #1 got = dout;
         exp = exp_q.pop_front();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL kbd_sync_clk%0d: got %h required %h", i, got, exp);
         end
      end
      @(negedge clk);
      iorq_n = 1'b1; rd_n = 1'b1;
   endtask

   task automatic test_palette();
      io_write(8'hF5, 8'h11);
      io_write(8'hFA, 8'h66);
      io_write(8'hFE, 8'h5A);
      io_write(8'hFB, 8'h99);
      checks++;
      if (pal !== {8'h66, 32'h0, 8'h11} || bg_mask !== 8'h5A) begin
         errors++;
         $display("FAIL palette_outputs: pal=%h bg=%h required 660000000011 5a", pal, bg_mask);
      end
      exp_q.push_back(8'h66);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h5A);
      io_read(8'hFA, got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL read_FA: got %h required %h", got, exp); end
      io_read(8'hFB, got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL read_FB: got %h required %h", got, exp); end
      io_read(8'hFE, got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL read_FE: got %h required %h", got, exp); end
   endtask

   task automatic test_interrupt();
      io_write(8'hFD, 8'h01);
      @(negedge clk);
      vb = 1'b1;
      wait_int_low(4, "vb_int_latency");
      @(negedge clk);
      iorq_n = 1'b0; m1_n = 1'b0;
      #1;
      checks++;
      if (dout !== 8'hFF) begin errors++; $display("FAIL ack_vector_start: got %h required ff", dout); end
      @(negedge clk);
      checks++;
      if (int_n !== 1'b0 || dout !== 8'hFF) begin
         errors++;
         $display("FAIL ack_first_clk: int_n=%b dout=%h required 0 ff", int_n, dout);
      end
      @(negedge clk);
      checks++;
      if (int_n !== 1'b1 || dout !== 8'hFF) begin
         errors++;
         $display("FAIL ack_release: int_n=%b dout=%h required 1 ff", int_n, dout);
      end
      iorq_n = 1'b1; m1_n = 1'b1;
      vb = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_masked_pending();
      logic seen_low = 1'b0;
      io_write(8'hFD, 8'h00);
      @(negedge clk);
      vb = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (int_n !== 1'b1) seen_low = 1'b1;
      end
      vb = 1'b0;
      checks++;
      if (seen_low) begin errors++; $display("FAIL masked_int_n: int_n went 0, required 1"); end
      exp_q.push_back(8'h02);
      io_read(8'hFD, got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL read_FD_masked: got %h required %h", got, exp); end
      io_write(8'hFD, 8'h01);
      checks++;
      if (int_n !== 1'b0) begin errors++; $display("FAIL unmask_int_n: got %b required 0", int_n); end
      io_write(8'hFD, 8'h00);
      checks++;
      if (int_n !== 1'b1) begin errors++; $display("FAIL remask_int_n: got %b required 1", int_n); end
      exp_q.push_back(8'h02);
      exp_q.push_back(8'h01);
      io_read(8'hFD, got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL read_FD_remask: got %h required %h", got, exp); end
      io_write(8'hFD, 8'h03);
      checks++;
      if (int_n !== 1'b1) begin errors++; $display("FAIL clear_int_n: got %b required 1", int_n); end
      io_read(8'hFD, got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL read_FD_cleared: got %h required %h", got, exp); end
   endtask

   task automatic test_collision();
      @(negedge clk);
      vb = 1'b1;
      wait_int_low(6, "collision_setup");
      vb = 1'b0;
      repeat (4) @(negedge clk);
      // vb rises at N0; the synchronised edge lands on the same clk the ack starts
      vb = 1'b1;
      repeat (2) @(negedge clk);
      iorq_n = 1'b0; m1_n = 1'b0;
      repeat (2) begin
         @(negedge clk);
         checks++;
         if (int_n !== 1'b0) begin errors++; $display("FAIL collision_int_n: got %b required 0", int_n); end
      end
      iorq_n = 1'b1; m1_n = 1'b1;
      vb = 1'b0;
      exp_q.push_back(8'h03);
      exp_q.push_back(8'h00);
      io_read(8'hFD, got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL collision_pend: got %h required %h", got, exp); end
      io_read(8'h10, got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL read_unmapped_10: got %h required %h", got, exp); end
      @(negedge clk);
      checks++;
      if (dout !== 8'h00) begin errors++; $display("FAIL idle_dout: got %h required 00", dout); end
   endtask

   initial begin
      reset = 1'b1;
      iorq_n = 1'b1; m1_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
      addr = 8'h00; din = 8'h00; vb = 1'b0; kbd_cols = 8'h00;
      test_reset();
      test_bank_regs();
      test_keyboard();
      test_palette();
      test_interrupt();
      test_masked_pending();
      test_collision();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
